// File: rtl/csr_apb_bridge_pkg.sv
// Shared types for the APB-to-CSR bridge: FSM state encoding, cpuif widths
// and the byte-strobe to bit-enable expansion.
package csr_bridge_pkg;

  localparam int CPUIF_DATA_W = 32;
  localparam int CPUIF_STRB_W = CPUIF_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } bridge_state_e;

  function automatic logic [CPUIF_DATA_W-1:0] strb_to_biten(input logic [CPUIF_STRB_W-1:0] strb);
    logic [CPUIF_DATA_W-1:0] biten;
    for (int i = 0; i < CPUIF_STRB_W; i++) begin
      biten[8*i +: 8] = {8{strb[i]}};
    end
    return biten;
  endfunction

endpackage

// File: rtl/csr_apb_bridge_if.sv
// APB4 completer bus plus the register block's single-request cpuif.
// slave = the bridge's view, master = requester and register block together.
interface csr_apb_bridge_if #(parameter int ADDR_W = 8);
  import csr_bridge_pkg::*;

  // APB: a transfer is accepted when psel & penable; it ends on the one cycle pready is high.
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_W-1:0]       paddr;
  logic [CPUIF_DATA_W-1:0] pwdata;
  logic [CPUIF_STRB_W-1:0] pstrb;
  logic                    pready;
  logic [CPUIF_DATA_W-1:0] prdata;
  logic                    pslverr;

  logic                    cpuif_req;
  logic                    cpuif_req_is_wr;
  logic [ADDR_W-1:0]       cpuif_addr;
  logic [CPUIF_DATA_W-1:0] cpuif_wr_data;
  logic [CPUIF_DATA_W-1:0] cpuif_wr_biten;
  logic                    cpuif_rd_ack;
  logic                    cpuif_rd_err;
  logic [CPUIF_DATA_W-1:0] cpuif_rd_data;
  logic                    cpuif_wr_ack;
  logic                    cpuif_wr_err;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, prdata, pslverr,
    output cpuif_req, cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten,
    input  cpuif_rd_ack, cpuif_rd_err, cpuif_rd_data, cpuif_wr_ack, cpuif_wr_err
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, prdata, pslverr,
    input  cpuif_req, cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten,
    output cpuif_rd_ack, cpuif_rd_err, cpuif_rd_data, cpuif_wr_ack, cpuif_wr_err
  );

endinterface

// File: rtl/csr_apb_bridge_timeout.sv
// WAIT-state watchdog for the bridge; only instantiated when CSR_APB_TIMEOUT_EN is defined.
module csr_apb_timeout #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (run) begin
      count <= count + 8'd1;
    end
  end

  assign expired = run && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/csr_apb_bridge.sv
// APB4 completer driving the CSR block's cpuif: one request per access, pready held until ack.
// Optional WAIT timeout is built when CSR_APB_TIMEOUT_EN is defined.
module csr_apb_bridge
  import csr_bridge_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  csr_apb_bridge_if.slave bus,
  output bridge_state_e fsm_state
);

  if (DATA_W != CPUIF_DATA_W) begin : g_bad_data_w
    $error("csr_apb_bridge: DATA_W must be 32");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("csr_apb_bridge: TIMEOUT_CYCLES must be in 2..255");
  end

  bridge_state_e state;
  logic          access;
  logic          aligned;
  logic          ack_hit;
  logic          ack_err;
  logic          expired;

  assign access    = bus.psel && bus.penable;
  assign aligned   = (bus.paddr[1:0] == 2'b00);
  assign fsm_state = state;

  // Only the ack matching the captured direction counts; the other is ignored.
  assign ack_hit = bus.cpuif_req_is_wr ? bus.cpuif_wr_ack : bus.cpuif_rd_ack;
  assign ack_err = bus.cpuif_req_is_wr ? bus.cpuif_wr_err : bus.cpuif_rd_err;

`ifdef CSR_APB_TIMEOUT_EN
  csr_apb_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state == IDLE && access && aligned),
    .run     (state == WAIT),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= IDLE;
      bus.pready          <= 1'b0;
      bus.prdata          <= '0;
      bus.pslverr         <= 1'b0;
      bus.cpuif_req       <= 1'b0;
      bus.cpuif_req_is_wr <= 1'b0;
      bus.cpuif_addr      <= '0;
      bus.cpuif_wr_data   <= '0;
      bus.cpuif_wr_biten  <= '0;
    end else begin
      bus.cpuif_req <= 1'b0;
      bus.pready    <= 1'b0;
      bus.prdata    <= '0;
      bus.pslverr   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (access) begin
            if (!aligned) begin
              state       <= RESP;
              bus.pready  <= 1'b1;
              bus.pslverr <= 1'b1;
            end else begin
              state               <= WAIT;
              bus.cpuif_req       <= 1'b1;
              bus.cpuif_req_is_wr <= bus.pwrite;
              bus.cpuif_addr      <= {bus.paddr[ADDR_W-1:2], 2'b00};
              bus.cpuif_wr_data   <= bus.pwrite ? bus.pwdata : '0;
              bus.cpuif_wr_biten  <= bus.pwrite ? strb_to_biten(bus.pstrb) : '0;
            end
          end
        end
        WAIT: begin
          if (ack_hit) begin
            state       <= RESP;
            bus.pready  <= 1'b1;
            bus.pslverr <= ack_err;
            bus.prdata  <= bus.cpuif_req_is_wr ? '0 : bus.cpuif_rd_data;
          end else if (expired) begin
            state       <= RESP;
            bus.pready  <= 1'b1;
            bus.pslverr <= 1'b1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_apb_bridge.sv
// Self-checking bench for csr_apb_bridge: directed steps then random APB transfers
// against a transaction-level model. Timeout steps run when CSR_APB_TIMEOUT_EN is defined.
module tb_csr_apb_bridge;
  import csr_bridge_pkg::*;

  localparam int ADDR_W = 8;
  localparam int TMO    = 4;
  localparam int BOUND  = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  csr_apb_bridge_if #(.ADDR_W(ADDR_W)) bus ();
  bridge_state_e fsm_state;

  csr_apb_bridge #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];  // {pslverr, prdata} expected per completed access

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_flags"}, {28'd0, bus.pready, bus.pslverr, bus.cpuif_req, bus.cpuif_req_is_wr}, 32'd0);
    check({tag, "_prdata"}, bus.prdata, 32'd0);
    check({tag, "_addr"}, 32'(bus.cpuif_addr), 32'd0);
    check({tag, "_wdata"}, bus.cpuif_wr_data, 32'd0);
    check({tag, "_biten"}, bus.cpuif_wr_biten, 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'(IDLE));
  endtask

  task automatic bus_idle();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
    bus.cpuif_rd_ack = 1'b0; bus.cpuif_rd_err = 1'b0; bus.cpuif_rd_data = '0;
    bus.cpuif_wr_ack = 1'b0; bus.cpuif_wr_err = 1'b0;
  endtask

  // ack_dly < 0: never acked (timeout). Latency is counted from access cycle A.
  task automatic xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input int ack_dly, input logic [31:0] rdata,
                      input logic err, input logic stray, input logic drop, input logic b2b);
    logic        mis;
    logic        done;
    logic        clean;
    int          lat;
    int          reqs;
    int          k;
    logic [31:0] biten_e;
    logic [32:0] resp_e;

    mis = (addr % 4) != 0;
    biten_e = 32'd0;
    if (wr) for (int i = 0; i < 4; i++) if (strb[i]) biten_e = biten_e + (32'hFF << (8 * i));
    if (mis)               exp_q.push_back({1'b1, 32'd0});
    else if (ack_dly < 0)  exp_q.push_back({1'b1, 32'd0});
    else if (wr)           exp_q.push_back({err, 32'd0});
    else                   exp_q.push_back({err, rdata});
    lat = mis ? 1 : (ack_dly < 0 ? TMO + 1 : ack_dly + 2);

    bus.psel = 1'b1; bus.pwrite = wr; bus.paddr = addr; bus.pwdata = wdata; bus.pstrb = strb;
    bus.penable = 1'b0;
    if (!b2b) @(negedge clk);
    bus.penable = 1'b1;

    done = 1'b0; clean = 1'b1; reqs = 0; k = 0;
    while (!done && k < BOUND) begin
      @(negedge clk);
      k++;
      if (bus.cpuif_req) reqs++;
      if (k == 1) begin
        check("req_in_a1", {31'd0, bus.cpuif_req}, {31'd0, !mis});
        if (!mis) begin
          check("req_is_wr", {31'd0, bus.cpuif_req_is_wr}, {31'd0, wr});
          check("req_addr", 32'(bus.cpuif_addr), 32'(addr));
          check("req_wdata", bus.cpuif_wr_data, wr ? wdata : 32'd0);
          check("req_biten", bus.cpuif_wr_biten, biten_e);
        end
      end
      if (!mis && k == lat - 1 && k > 1) begin
        check("hold_addr", 32'(bus.cpuif_addr), 32'(addr));
        check("hold_biten", bus.cpuif_wr_biten, biten_e);
      end
      if (bus.pready) begin
        done = 1'b1;
        resp_e = exp_q.pop_front();
        check("latency", 32'(k), 32'(lat));
        check("pslverr", {31'd0, bus.pslverr}, {31'd0, resp_e[32]});
        check("prdata", bus.prdata, resp_e[31:0]);
      end else if (bus.prdata != 32'd0 || bus.pslverr) begin
        clean = 1'b0;
      end
      // Inputs for the current cycle (A+k).
      bus.cpuif_wr_ack = !done && !mis && wr  && ack_dly >= 0 && k == 1 + ack_dly;
      bus.cpuif_rd_ack = !done && !mis && !wr && ack_dly >= 0 && k == 1 + ack_dly;
      bus.cpuif_wr_err = bus.cpuif_wr_ack ? err : 1'($urandom_range(0, 1));
      bus.cpuif_rd_err = bus.cpuif_rd_ack ? err : 1'($urandom_range(0, 1));
      bus.cpuif_rd_data = bus.cpuif_rd_ack ? rdata : $urandom;
      if (stray && !done && !mis && k == 1 && ack_dly >= 1) begin
        if (wr) bus.cpuif_rd_ack = 1'b1;
        else    bus.cpuif_wr_ack = 1'b1;
      end
      if ((drop && k == 1) || done) begin
        bus.psel = 1'b0; bus.penable = 1'b0;
      end
    end
    if (!done) begin
      check("pready_seen", 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end
    check("req_count", 32'(reqs), mis ? 32'd0 : 32'd1);
    check("clean_outside_resp", {31'd0, clean}, 32'd1);
    bus_idle();
    @(negedge clk);
    check("pready_one_cycle", {31'd0, bus.pready}, 32'd0);
  endtask

  initial begin
    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios.
    xfer(1'b1, 8'h08, 32'hA5A5_1234, 4'b0011, 0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    xfer(1'b0, 8'h0C, 32'd0, 4'b0000, 2, 32'h0000_01FF, 1'b0, 1'b0, 1'b0, 1'b0);
    xfer(1'b0, 8'h03, 32'd0, 4'b0000, 0, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
    xfer(1'b1, 8'h10, 32'hCAFE_F00D, 4'b1111, 2, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    xfer(1'b0, 8'h20, 32'd0, 4'b0000, 1, 32'h8765_4321, 1'b0, 1'b0, 1'b1, 1'b1);
    xfer(1'b1, 8'h24, 32'h0F0F_0F0F, 4'b1010, 0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef CSR_APB_TIMEOUT_EN
    xfer(1'b0, 8'h30, 32'd0, 4'b0000, -1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Now in A+6; drive a late read ack in A+7 while the bridge is idle.
    @(negedge clk);
    bus.cpuif_rd_ack = 1'b1; bus.cpuif_rd_data = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.cpuif_rd_ack = 1'b0;
    check("late_ack_pready", {31'd0, bus.pready}, 32'd0);
    check("late_ack_state", 32'(fsm_state), 32'(IDLE));
    xfer(1'b0, 8'h34, 32'd0, 4'b0000, 1, 32'h0000_00AA, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // Reset asserted while a read sits in WAIT.
    bus.psel = 1'b1; bus.pwrite = 1'b0; bus.paddr = 8'h40; bus.penable = 1'b0;
    @(negedge clk);
    bus.penable = 1'b1;
    @(negedge clk);
    check("rst_mid_req", {31'd0, bus.cpuif_req}, 32'd1);
    rst_n = 1'b0;
    bus_idle();
    @(negedge clk);
    check_all_zero("rst_mid");
    rst_n = 1'b1;
    xfer(1'b1, 8'h44, 32'h1357_9BDF, 4'b0100, 0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Random transfers.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] a;
      logic       w;
      int         d;
      a = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      w = 1'($urandom_range(0, 1));
      d = $urandom_range(0, 4);
      xfer(w, a, $urandom, 4'($urandom_range(0, 15)), d, $urandom,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
    end

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
